seg_scanner: RTL and testbench
==============================

SEG_SCANNER -- requirements
Module: seg_scanner

Interface
REQ-001 SHALL have parameter DIGITS, default 2, number of multiplexed digit positions, legal range 1..8.
REQ-002 SHALL have parameter SCAN_DIV, default 100000, clk cycles per digit slot, legal range >= 2.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset; 0 resets all state immediately.
REQ-005 SHALL have port digits_in  input  4*DIGITS  BCD digits, nibble k = position k, with position 0 the units digit.
REQ-006 SHALL have port dp_in  input  DIGITS  decimal point per position, active-high.
REQ-007 SHALL have port load  input  1  when 1 at a rising edge, digits_in and dp_in are captured into the shadow register.
REQ-008 SHALL have port enable  input  1  when 0, all digits are dark while scanning continues.
REQ-009 SHALL have port illuminate  output  8  digit enables, active-low, bit k = position k.
REQ-010 SHALL have port segment  output  8  segments abcdefg+dp, active-low, bit7=a ... bit1=g, bit0=dp.
REQ-011 SHALL have port frame_start  output  1  one-cycle pulse when scanning wraps to position 0.
REQ-012 SHALL have port pending  output  1  1 while shadow data is not yet shown on the display.

Function
REQ-013 Prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; tick = (count == SCAN_DIV-1).
REQ-014 Scan index SHALL advance by 1 on each tick and wrap from DIGITS-1 to 0; with DIGITS=1 it SHALL stay 0.
REQ-015 Frame wrap SHALL be a tick with index == DIGITS-1; frame_start SHALL be 1 in the cycle after a frame wrap and 0 otherwise.
REQ-016 On load=1 the shadow register SHALL be updated and pending SHALL be set, irrespective of the current scan position.
REQ-017 On a frame wrap the display register SHALL take the shadow contents and pending SHALL clear.
REQ-018 If load=1 in the same cycle as a frame wrap, the display register SHALL take digits_in/dp_in directly (bypass), and pending SHALL end at 0.
REQ-019 illuminate and segment SHALL be registered, reflecting the scan index and display register one cycle after they change.
REQ-020 illuminate SHALL be all ones except bit[index], which is 0; bits >= DIGITS SHALL always be 1.
REQ-021 segment[7:1] SHALL decode as 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; values 10..15 SHALL give 1111111 (blank).
REQ-022 segment[0] SHALL be the inverse of the displayed dp bit of the current position.
REQ-023 enable=0 SHALL force illuminate=8'hFF and segment=8'hFF on the next edge; the prescaler, index, load and pending logic SHALL continue unaffected.

Reset
REQ-024 On reset=0: prescaler=0, index=0, shadow=0, display=0, pending=0, frame_start=0, illuminate=8'hFF, segment=8'hFF.
REQ-025 Reset asserted mid-frame or mid-load SHALL discard the shadow and pending contents without any output glitch other than the REQ-024 values.
REQ-026 At the first rising edge after release with enable=1, outputs SHALL be illuminate=8'b11111110 and segment=8'b00000011.

Configuration
REQ-027 Macro LEADING_ZERO_BLANK_EN defined: positions above the highest non-zero displayed digit whose value is 0 SHALL show segment[7:1]=1111111, with dp still per REQ-022; position 0 SHALL never be blanked.
REQ-028 Macro LEADING_ZERO_BLANK_EN undefined: all zero digits SHALL display as 0, with no blanking logic present.

Verification (bench: DIGITS=4, SCAN_DIV=4, enable=1)
REQ-029 Release reset, load digits_in=16'h0102 -> display still 0000 until frame wrap; frame_start pulses once; then positions 0..3 show 2,0,1,0 with illuminate FE,FD,FB,F7, each for 4 cycles.
REQ-030 Load 16'h1234 in the frame-wrap cycle -> pending stays 0; the next frame shows 4,3,2,1 with no intermediate frame.
REQ-031 digits_in=16'h00AF, dp_in=4'b0010 -> positions 0,1 show segment 8'hFF and 8'hFE; positions 2,3 show 0 (no macro) or blank 8'hFF (LEADING_ZERO_BLANK_EN).
REQ-032 Drop enable for 10 cycles -> illuminate=8'hFF and segment=8'hFF; the scan index on re-enable matches the free-running count.
REQ-033 Assert reset mid-slot with pending=1 -> outputs 8'hFF, pending=0; after release, display shows 0000 until the next load.

Source files
------------

// File: rtl/seg_scanner.sv
// Time-multiplexed 7-segment scanner with a double-buffered shadow/display register.
// Optional leading-zero blanking is compiled in when LEADING_ZERO_BLANK_EN is defined.
module seg_scanner #(
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  enable,
    output logic [7:0]            illuminate,
    output logic [7:0]            segment,
    output logic                  frame_start,
    output logic                  pending
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [2:0]    IDX_MAX = 3'(DIGITS - 1);

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          idx_q, idx_d;
    logic [4*DIGITS-1:0] shadow_dig_q, shadow_dig_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [4*DIGITS-1:0] disp_dig_q, disp_dig_d;
    logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic                pending_q, pending_d;
    logic                frame_start_q;
    logic [7:0]          illum_q, illum_d;
    logic [7:0]          seg_q, seg_d;

    logic                tick;
    logic                wrap;
    logic [3:0]          cur_dig;
    logic                cur_dp;
    logic                cur_blank;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Prescaler, scan index and double-buffer next state
    always_comb begin
        tick = (cnt_q == CNT_MAX);
        wrap = tick && (idx_q == IDX_MAX);

        cnt_d = tick ? '0 : cnt_q + CW'(1);

        idx_d = idx_q;
        if (tick) begin
            idx_d = wrap ? 3'd0 : idx_q + 3'd1;
        end

        shadow_dig_d = load ? digits_in : shadow_dig_q;
        shadow_dp_d  = load ? dp_in     : shadow_dp_q;

        disp_dig_d = disp_dig_q;
        disp_dp_d  = disp_dp_q;
        pending_d  = pending_q;
        if (wrap) begin
            // A load coinciding with the wrap bypasses the shadow straight to the display
            disp_dig_d = load ? digits_in : shadow_dig_q;
            disp_dp_d  = load ? dp_in     : shadow_dp_q;
            pending_d  = 1'b0;
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    // Current-position digit select and output next state
`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] zero_from;
    logic              all_zero;
`endif

    always_comb begin
        cur_dig   = 4'd0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        illum_d   = 8'hFF;

`ifdef LEADING_ZERO_BLANK_EN
        // zero_from[k]: every displayed digit at position k and above is zero
        zero_from = '0;
        all_zero  = 1'b1;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            all_zero                 = all_zero && (disp_dig_q[4*(DIGITS-1-j) +: 4] == 4'd0);
            zero_from[DIGITS-1-j]    = all_zero;
        end
`endif

        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx_q == 3'(k)) begin
                cur_dig    = disp_dig_q[4*k +: 4];
                cur_dp     = disp_dp_q[k];
                illum_d[k] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
                cur_blank  = (k != 0) && zero_from[k];
`endif
            end
        end

        seg_d = {cur_blank ? 7'b1111111 : decode(cur_dig), ~cur_dp};

        if (!enable) begin
            illum_d = 8'hFF;
            seg_d   = 8'hFF;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q         <= '0;
            idx_q         <= 3'd0;
            shadow_dig_q  <= '0;
            shadow_dp_q   <= '0;
            disp_dig_q    <= '0;
            disp_dp_q     <= '0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
            illum_q       <= 8'hFF;
            seg_q         <= 8'hFF;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_dig_q  <= shadow_dig_d;
            shadow_dp_q   <= shadow_dp_d;
            disp_dig_q    <= disp_dig_d;
            disp_dp_q     <= disp_dp_d;
            pending_q     <= pending_d;
            frame_start_q <= wrap;
            illum_q       <= illum_d;
            seg_q         <= seg_d;
        end
    end

    assign illuminate  = illum_q;
    assign segment     = seg_q;
    assign frame_start = frame_start_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_seg_scanner.sv
// Randomized bench for seg_scanner (DIGITS=4, SCAN_DIV=4) against a cycle-count based model.
// Honours LEADING_ZERO_BLANK_EN when the bench is built with it defined.
module tb_seg_scanner;

    localparam int DIG = 4;
    localparam int SD  = 4;
    localparam int FRAME = DIG * SD;

    localparam logic [6:0] SEG_TAB [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        enable;
    logic [7:0]  illuminate;
    logic [7:0]  segment;
    logic        frame_start;
    logic        pending;

    seg_scanner #(
        .DIGITS   (DIG),
        .SCAN_DIV (SD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .load        (load),
        .enable      (enable),
        .illuminate  (illuminate),
        .segment     (segment),
        .frame_start (frame_start),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total    = 0;
    int fail_cnt = 0;
    bit run_cmp  = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Model: position and tick follow purely from cycles elapsed since reset release
    int        m_cycle;
    int        sh_dig [DIG];
    int        sh_dp  [DIG];
    int        ds_dig [DIG];
    int        ds_dp  [DIG];
    bit        m_pend;
    logic [7:0] exp_il, exp_sg;
    bit        exp_fs;

    function automatic logic [7:0] seg_for(input int pos);
        int         hi;
        logic [6:0] s;
        hi = -1;
        for (int p = 0; p < DIG; p++) if (ds_dig[p] != 0) hi = p;
        if (ds_dig[pos] > 9) s = 7'h7F;
        else if (LZB && pos > 0 && pos > hi) s = 7'h7F;
        else s = SEG_TAB[ds_dig[pos]];
        return {s, ~ds_dp[pos][0]};
    endfunction

    task automatic model_step();
        int idx;
        bit wrap;
        if (!reset) begin
            m_cycle = 0;
            m_pend  = 0;
            for (int p = 0; p < DIG; p++) begin
                sh_dig[p] = 0; sh_dp[p] = 0; ds_dig[p] = 0; ds_dp[p] = 0;
            end
            exp_il = 8'hFF;
            exp_sg = 8'hFF;
            exp_fs = 0;
        end else begin
            idx  = (m_cycle / SD) % DIG;
            wrap = (m_cycle % SD == SD - 1) && (idx == DIG - 1);
            if (enable) begin
                exp_il = 8'hFF & ~(8'd1 << idx);
                exp_sg = seg_for(idx);
            end else begin
                exp_il = 8'hFF;
                exp_sg = 8'hFF;
            end
            exp_fs = wrap;
            if (wrap) begin
                for (int p = 0; p < DIG; p++) begin
                    ds_dig[p] = load ? int'(digits_in[4*p +: 4]) : sh_dig[p];
                    ds_dp[p]  = load ? int'(dp_in[p])            : sh_dp[p];
                end
                m_pend = 0;
            end else if (load) begin
                m_pend = 1;
            end
            if (load) begin
                for (int p = 0; p < DIG; p++) begin
                    sh_dig[p] = int'(digits_in[4*p +: 4]);
                    sh_dp[p]  = int'(dp_in[p]);
                end
            end
            m_cycle++;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (run_cmp) begin
            chk("illuminate", illuminate, exp_il);
            chk("segment", segment, exp_sg);
            chk("frame_start", {7'd0, frame_start}, {7'd0, exp_fs});
            chk("pending", {7'd0, pending}, {7'd0, m_pend});
        end
    end

    task automatic sync_wrap();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((m_cycle % FRAME) != 0 && n < 3 * FRAME);
        if (n >= 3 * FRAME) chk("sync_timeout", 8'd1, 8'd0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0;
        #3 reset = 1'b0;
        #1;
        chk("rst_illum", illuminate, 8'hFF);
        chk("rst_seg", segment, 8'hFF);
        chk("rst_pending", {7'd0, pending}, 8'd0);
        run_cmp = 1'b1;
        @(negedge clk) reset = 1'b1;

        // First edge after release shows digit 0 of an all-zero display
        @(negedge clk);
        chk("first_illum", illuminate, 8'hFE);
        chk("first_seg", segment, 8'h03);
        load = 1'b1; digits_in = 16'h0102; dp_in = 4'b0000;
        @(negedge clk) load = 1'b0;
        chk("load_pending", {7'd0, pending}, 8'd1);
        repeat (14) @(negedge clk);
        chk("wrap_fs", {7'd0, frame_start}, 8'd1);
        chk("wrap_pending", {7'd0, pending}, 8'd0);
        @(negedge clk);
        chk("f1_pos0_il", illuminate, 8'hFE);
        chk("f1_pos0_sg", segment, 8'h25);
        repeat (4) @(negedge clk);
        chk("f1_pos1_il", illuminate, 8'hFD);
        chk("f1_pos1_sg", segment, 8'h03);
        repeat (4) @(negedge clk);
        chk("f1_pos2_il", illuminate, 8'hFB);
        chk("f1_pos2_sg", segment, 8'h9F);
        repeat (4) @(negedge clk);
        chk("f1_pos3_il", illuminate, 8'hF7);
        chk("f1_pos3_sg", segment, LZB ? 8'hFF : 8'h03);

        // Load exactly in the frame-wrap cycle
        repeat (2) @(negedge clk);
        load = 1'b1; digits_in = 16'h1234;
        @(negedge clk) load = 1'b0;
        chk("bypass_pending", {7'd0, pending}, 8'd0);
        chk("bypass_fs", {7'd0, frame_start}, 8'd1);
        @(negedge clk);
        chk("bypass_pos0_sg", segment, 8'h99);

        // Non-decimal codes and decimal point
        load = 1'b1; digits_in = 16'h00AF; dp_in = 4'b0010;
        @(negedge clk) load = 1'b0; dp_in = 4'b0000;
        sync_wrap();
        @(negedge clk);
        chk("hex_pos0_sg", segment, 8'hFF);
        repeat (4) @(negedge clk);
        chk("hex_pos1_sg", segment, 8'hFE);
        repeat (4) @(negedge clk);
        chk("hex_pos2_sg", segment, LZB ? 8'hFF : 8'h03);
        repeat (4) @(negedge clk);
        chk("hex_pos3_sg", segment, LZB ? 8'hFF : 8'h03);

        // Enable dropout
        enable = 1'b0;
        @(negedge clk);
        chk("dark_illum", illuminate, 8'hFF);
        chk("dark_seg", segment, 8'hFF);
        repeat (9) @(negedge clk);
        enable = 1'b1;
        repeat (8) @(negedge clk);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            load      = ($urandom_range(0, 4) == 0);
            digits_in = 16'($urandom);
            dp_in     = 4'($urandom);
            if ($urandom_range(0, 40) == 0) enable = ~enable;
        end
        @(negedge clk);
        load = 1'b0; enable = 1'b1;
        repeat (4) @(negedge clk);

        // Reset mid-slot while a load is pending
        sync_wrap();
        repeat (3) @(negedge clk);
        load = 1'b1; digits_in = 16'h5678; dp_in = 4'b1111;
        @(negedge clk) load = 1'b0;
        chk("pre_rst_pending", {7'd0, pending}, 8'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_illum", illuminate, 8'hFF);
        chk("mid_rst_seg", segment, 8'hFF);
        chk("mid_rst_pending", {7'd0, pending}, 8'd0);
        chk("mid_rst_fs", {7'd0, frame_start}, 8'd0);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        chk("post_rst_illum", illuminate, 8'hFE);
        chk("post_rst_seg", segment, 8'h03);
        repeat (2 * FRAME + 4) @(negedge clk);

        run_cmp = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
